// File: rtl/sram_port_arbiter_pkg.sv
// Shared state and grant encodings for the SRAM port arbiter and the read-side
// prefetch controller that works against the same bank.
package sram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WSETUP = 3'd1,
    ST_WPULSE = 3'd2,
    ST_WHOLD  = 3'd3,
    ST_RREAD  = 3'd4,
    ST_RDONE  = 3'd5,
    ST_TURN   = 3'd6
  } arb_state_e;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

  // Width of the phase counter: enough for the longer of the two strobe phases plus one bit.
  function automatic int cnt_width(input int we_cycles, input int rd_cycles);
    int mx;
    mx = (we_cycles > rd_cycles) ? we_cycles : rd_cycles;
    return $clog2(mx) + 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one async 16-bit SRAM bank between the pixel-packer
// write port and the rotated-coordinate read port. Generates registered addr/web/oeb,
// owns the tristate data bus, and inserts a turnaround cycle after every read.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 16,
  parameter int WE_CYCLES  = 1,
  parameter int RD_CYCLES  = 2
) (
  input  logic                  img_clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  web,
  output logic                  oeb,
  inout  wire  [DATA_WIDTH-1:0] ram_databus,
  output logic                  busy
);

  localparam int CW = cnt_width(WE_CYCLES, RD_CYCLES);
  localparam logic [CW-1:0] WE_LOAD = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  grant_e                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  web_q, web_d;
  logic                  oeb_q, oeb_d;
  logic                  drive_en_q, drive_en_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  pick_wr;

  // Next-state, grant selection and registered strobe values derived from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    // A tie goes to whichever side was not served last.
    pick_wr      = wr_req && (!rd_req || (last_grant_q == GNT_RD));

    case (state_q)
      ST_IDLE: begin
        if (enable && (wr_req || rd_req)) begin
          if (pick_wr) begin
            state_d      = ST_WSETUP;
            last_grant_d = GNT_WR;
            addr_d       = wr_addr;
            wdata_d      = wr_data;
          end else begin
            state_d      = ST_RREAD;
            last_grant_d = GNT_RD;
            addr_d       = rd_addr;
            cnt_d        = RD_LOAD;
          end
        end
      end
      ST_WSETUP: begin
        state_d = ST_WPULSE;
        cnt_d   = WE_LOAD;
      end
      ST_WPULSE: begin
        if (cnt_q == '0) state_d = ST_WHOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_WHOLD: state_d = ST_IDLE;
      ST_RREAD: begin
        // Capture on the last edge of the oeb-low window.
        if (cnt_q == '0) begin
          rd_data_d = ram_databus;
          state_d   = ST_RDONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RDONE: state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    web_d      = (state_d != ST_WPULSE);
    oeb_d      = (state_d != ST_RREAD);
    drive_en_d = (state_d == ST_WSETUP) || (state_d == ST_WPULSE) || (state_d == ST_WHOLD);
    wr_ack_d   = (state_d == ST_WHOLD);
    rd_ack_d   = (state_d == ST_RDONE);
  end

  // Control and SRAM-facing registers; reset aborts any access without acking.
  always_ff @(posedge img_clk) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GNT_RD;
      addr_q       <= '0;
      rd_data_q    <= '0;
      web_q        <= 1'b1;
      oeb_q        <= 1'b1;
      drive_en_q   <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rd_data_q    <= rd_data_d;
      web_q        <= web_d;
      oeb_q        <= oeb_d;
      drive_en_q   <= drive_en_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
    end
  end

  // Write data holding register; only observable on the bus while drive_en is set.
  always_ff @(posedge img_clk) begin
    wdata_q <= wdata_d;
  end

  assign ram_databus = drive_en_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign addr    = addr_q;
  assign web     = web_q;
  assign oeb     = oeb_q;
  assign wr_ack  = wr_ack_q;
  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a simple async SRAM model on the bus.
module tb_sram_port_arbiter;

  localparam int AW = 21;
  localparam int DW = 16;

  logic          img_clk = 1'b0;
  logic          resetb;
  logic          enable;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] addr;
  logic          web;
  logic          oeb;
  wire  [DW-1:0] ram_databus;
  logic          busy;

  int n_cmp = 0;
  int n_mis = 0;
  int excl_viol = 0;

  // SRAM model: drives the bus while oeb low and web high, writes while web low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          sram_oe;
  logic [DW-1:0] sram_rdata;
  assign sram_oe     = !oeb && web;
  assign sram_rdata  = mem[addr];
  assign ram_databus = sram_oe ? sram_rdata : {DW{1'bz}};

  always @(posedge img_clk) begin
    if (!web) mem[addr] <= ram_databus;
  end

  always #5 img_clk = ~img_clk;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_CYCLES(1), .RD_CYCLES(2)) dut (
    .img_clk(img_clk), .resetb(resetb), .enable(enable),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .addr(addr), .web(web), .oeb(oeb), .ram_databus(ram_databus), .busy(busy)
  );

  always @(negedge img_clk) begin
    if (!web && !oeb) excl_viol++;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for a grant, then follows the access until its ack. Cycle 1 is the first
  // sample after the grant edge. The request being served is dropped on the ack cycle.
  task automatic run_access(input bit is_wr, output int ack_cyc, output int low_cyc,
                            output logic [DW-1:0] dat, output logic [AW-1:0] adr);
    int t;
    ack_cyc = 0; low_cyc = 0; dat = '0; adr = '0;
    t = 0;
    do begin
      @(negedge img_clk);
      t++;
    end while (!busy && t < 20);
    if (!busy) begin
      chk_val("grant_timeout", 32'(busy), 32'd1);
      return;
    end
    for (int c = 1; c <= 12; c++) begin
      if (is_wr ? !web : !oeb) low_cyc++;
      if (is_wr ? wr_ack : rd_ack) begin
        ack_cyc = c;
        dat = rd_data;
        adr = addr;
        if (is_wr) wr_req = 1'b0;
        else       rd_req = 1'b0;
        return;
      end
      @(negedge img_clk);
    end
  endtask

  initial begin
    int ack_c, low_c, gcnt, t;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic prev_busy, expect_turn;
    logic [1:0] acks;

    resetb = 1'b0; enable = 1'b1;
    wr_req = 1'b1; rd_req = 1'b0;
    wr_addr = 21'h1ABCD; wr_data = 16'h5A3C; rd_addr = 21'h1ABCD;

    // Reset held with a write pending
    for (int i = 0; i < 3; i++) begin
      @(negedge img_clk);
      chk_val("rst_strobes", {29'd0, web, oeb, busy}, 32'b110);
      chk_val("rst_acks", {30'd0, wr_ack, rd_ack}, 32'd0);
    end
    chk_val("rst_addr", 32'(addr), 32'd0);
    chk_val("rst_rd_data", 32'(rd_data), 32'd0);

    // Single write
    resetb = 1'b1;
    run_access(1'b1, ack_c, low_c, d, a);
    chk_val("wr_ack_cycle", 32'(ack_c), 32'd3);
    chk_val("wr_web_low_cycles", 32'(low_c), 32'd1);
    chk_val("wr_addr_out", 32'(a), 32'h1ABCD);
    @(negedge img_clk);
    @(negedge img_clk);
    chk_val("wr_idle_after", 32'(busy), 32'd0);
    chk_val("mem_1abcd", 32'(mem[21'h1ABCD]), 32'h5A3C);

    // Read back
    rd_req = 1'b1;
    run_access(1'b0, ack_c, low_c, d, a);
    chk_val("rd_ack_cycle", 32'(ack_c), 32'd3);
    chk_val("rd_oeb_low_cycles", 32'(low_c), 32'd2);
    chk_val("rd_data", 32'(d), 32'h5A3C);
    @(negedge img_clk);
    chk_val("rd_turn", {29'd0, busy, rd_ack, oeb}, 32'b101);
    @(negedge img_clk);
    chk_val("rd_idle_after_turn", 32'(busy), 32'd0);
    chk_val("rd_data_held", 32'(rd_data), 32'h5A3C);

    // Both requesting from reset: strict alternation W,R,W,R...
    resetb = 1'b0;
    wr_addr = 21'h00010; wr_data = 16'h1234; rd_addr = 21'h1ABCD;
    wr_req = 1'b1; rd_req = 1'b1;
    @(negedge img_clk);
    resetb = 1'b1;
    gcnt = 0; prev_busy = 1'b0; expect_turn = 1'b0; t = 0;
    while (gcnt < 8 && t < 200) begin
      @(negedge img_clk);
      t++;
      if (expect_turn) begin
        chk_val("alt_turn", {29'd0, busy, rd_ack, oeb}, 32'b101);
        expect_turn = 1'b0;
      end
      if (rd_ack) begin
        chk_val("alt_rd_data", 32'(rd_data), 32'h5A3C);
        expect_turn = 1'b1;
      end
      if (busy && !prev_busy) begin
        // A read grant shows oeb low on its first cycle; a write grant does not.
        chk_val($sformatf("alt_grant%0d_is_wr", gcnt), 32'(oeb), (gcnt % 2 == 0) ? 32'd1 : 32'd0);
        gcnt++;
      end
      prev_busy = busy;
    end
    chk_val("alt_grant_count", 32'(gcnt), 32'd8);
    wr_req = 1'b0; rd_req = 1'b0;
    t = 0;
    while (busy && t < 20) begin
      @(negedge img_clk);
      t++;
    end
    chk_val("alt_drained", 32'(busy), 32'd0);
    chk_val("mem_0010", 32'(mem[21'h00010]), 32'h1234);

    // Reset during the write pulse
    wr_addr = 21'h00020; wr_data = 16'hBEEF; wr_req = 1'b1;
    t = 0;
    do begin
      @(negedge img_clk);
      t++;
    end while (!busy && t < 20);
    @(negedge img_clk);
    chk_val("midrst_in_wpulse", 32'(web), 32'd0);
    resetb = 1'b0;
    @(negedge img_clk);
    chk_val("midrst_abort", {29'd0, web, busy, wr_ack}, 32'b100);
    wr_req = 1'b0;
    @(negedge img_clk);
    resetb = 1'b1;
    acks = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge img_clk);
      acks = acks | {wr_ack, busy};
    end
    chk_val("midrst_no_ack_idle", 32'(acks), 32'd0);

    // enable low blocks grants; enable high grants the write first
    enable = 1'b0;
    wr_addr = 21'h00030; wr_data = 16'h7E81;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge img_clk);
      chk_val("en_off_busy", {30'd0, busy, wr_ack | rd_ack}, 32'd0);
    end
    enable = 1'b1;
    @(negedge img_clk);
    chk_val("en_on_write_granted", {29'd0, busy, web, oeb}, 32'b111);
    t = 0;
    while (!wr_ack && t < 10) begin
      @(negedge img_clk);
      t++;
    end
    chk_val("en_on_wr_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge img_clk);
    @(negedge img_clk);
    chk_val("en_on_idle", 32'(busy), 32'd0);
    chk_val("mem_0030", 32'(mem[21'h00030]), 32'h7E81);

    chk_val("web_oeb_exclusive", 32'(excl_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
